// File: rtl/sys_ram_arb.sv
// sys_ram_arb: system RAM with a power-on clear sequencer, a CPU write-protect
// window, and a loader port. The loader gets only the cycles the CPU leaves idle.
// The CPU has absolute priority with one-cycle read latency. The loader uses a
// req/ack handshake. All traffic shares a single inferred RAM port with a
// registered read.
module sys_ram_arb #(
    parameter int unsigned        DATA_W      = 8,
    parameter int unsigned        ADDR_W      = 16,
    parameter int unsigned        DEPTH       = 49152,
    parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0,
    parameter int unsigned        WP_BASE     = 0,
    parameter int unsigned        WP_LIMIT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_cs,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_w_en,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              wp_en,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_address,
    input  logic [DATA_W-1:0] ldr_din,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_dout,
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q_reg;

    // Shared RAM port, driven by whichever agent owns the current cycle
    logic              port_en;
    logic              port_we;
    logic [IDX_W-1:0]  port_idx;
    logic [DATA_W-1:0] port_din;

    logic              cpu_rd, cpu_rd_reg, cpu_oor_reg;
    logic [DATA_W-1:0] cpu_hold_reg, cpu_hold_next;
    logic              ldr_grant, ldr_ack_reg, ldr_oor_reg;
    logic [DATA_W-1:0] ldr_hold_reg;

    logic cpu_in_range, ldr_in_range, cpu_in_wp;

    assign cpu_in_range = 64'(cpu_address) < 64'(DEPTH);
    assign ldr_in_range = 64'(ldr_address) < 64'(DEPTH);
    // An inverted window (WP_LIMIT < WP_BASE) never matches
    assign cpu_in_wp    = (64'(cpu_address) >= 64'(WP_BASE)) &&
                          (64'(cpu_address) <= 64'(WP_LIMIT));

    // Next-state, clear counter and RAM port ownership (clear > CPU > loader)
    always_comb begin
        state_next    = state_reg;
        clr_cnt_next  = clr_cnt_reg;
        port_en       = 1'b0;
        port_we       = 1'b0;
        port_idx      = '0;
        port_din      = '0;
        cpu_rd        = 1'b0;
        ldr_grant     = 1'b0;
        cpu_hold_next = cpu_dout;
        case (state_reg)
            ST_CLEAR: begin
                port_en  = 1'b1;
                port_we  = 1'b1;
                port_idx = clr_cnt_reg[IDX_W-1:0];
                port_din = CLEAR_VALUE;
                // CPU reads during clear see the clear pattern; writes are dropped
                if (cpu_cs) begin
                    cpu_hold_next = CLEAR_VALUE;
                end
                if (clr_cnt_reg == CLR_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (cpu_cs) begin
                    cpu_rd   = 1'b1;
                    port_en  = cpu_in_range;
                    port_we  = cpu_w_en && !(wp_en && cpu_in_wp);
                    port_idx = cpu_address[IDX_W-1:0];
                    port_din = cpu_din;
                end else if (ldr_req && !ldr_ack_reg) begin
                    // No grant during the ack cycle, so a held req cannot double-issue
                    ldr_grant = 1'b1;
                    port_en   = ldr_in_range;
                    port_we   = ldr_we;
                    port_idx  = ldr_address[IDX_W-1:0];
                    port_din  = ldr_din;
                end
            end
        endcase
    end

    // Single-port RAM: read-before-write, registered read data
    always_ff @(posedge clk) begin
        if (port_en && !reset) begin
            if (port_we) begin
                mem[port_idx] <= port_din;
            end
            ram_q_reg <= mem[port_idx];
        end
    end

    // State, counter and output bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_CLEAR;
            clr_cnt_reg  <= '0;
            cpu_rd_reg   <= 1'b0;
            cpu_oor_reg  <= 1'b0;
            cpu_hold_reg <= '0;
            ldr_ack_reg  <= 1'b0;
            ldr_oor_reg  <= 1'b0;
            ldr_hold_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_cnt_reg  <= clr_cnt_next;
            cpu_rd_reg   <= cpu_rd;
            cpu_oor_reg  <= !cpu_in_range;
            cpu_hold_reg <= cpu_hold_next;
            ldr_ack_reg  <= ldr_grant;
            ldr_oor_reg  <= !ldr_in_range;
            ldr_hold_reg <= ldr_dout;
        end
    end

    // The RAM output register is shared, so each port holds its own last value
    assign cpu_dout = cpu_rd_reg  ? (cpu_oor_reg ? '1 : ram_q_reg) : cpu_hold_reg;
    assign ldr_dout = ldr_ack_reg ? (ldr_oor_reg ? '1 : ram_q_reg) : ldr_hold_reg;
    assign ldr_ack  = ldr_ack_reg;
    assign busy     = (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_sys_ram_arb.sv
// Testbench for sys_ram_arb: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural memory/handshake model.
module tb_sys_ram_arb;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_cs = 1'b0;
    logic [4:0] cpu_address = '0;
    logic       cpu_w_en = 1'b0;
    logic [7:0] cpu_din = '0;
    logic [7:0] cpu_dout;
    logic       wp_en = 1'b0;
    logic       ldr_req = 1'b0;
    logic       ldr_we = 1'b0;
    logic [4:0] ldr_address = '0;
    logic [7:0] ldr_din = '0;
    logic       ldr_ack;
    logic [7:0] ldr_dout;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [7:0] m_mem [16];
    bit         m_clearing = 1'b1;
    int         m_clr_idx = 0;
    logic [7:0] m_cpu = '0;
    logic [7:0] m_ldr = '0;
    bit         m_ack = 1'b0;

    sys_ram_arb #(
        .DATA_W(8), .ADDR_W(5), .DEPTH(16), .CLEAR_VALUE(8'hA5),
        .WP_BASE(4), .WP_LIMIT(7)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_cs(cpu_cs), .cpu_address(cpu_address), .cpu_w_en(cpu_w_en),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .wp_en(wp_en),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_address(ldr_address),
        .ldr_din(ldr_din), .ldr_ack(ldr_ack), .ldr_dout(ldr_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [4:0] a);
        return (a < 5'd16) ? m_mem[a[3:0]] : 8'hFF;
    endfunction

    // Apply one clock edge of the specified behaviour to the model
    task automatic model_edge();
        bit nxt_ack;
        nxt_ack = 1'b0;
        if (reset) begin
            m_clearing = 1'b1;
            m_clr_idx  = 0;
            m_cpu      = 8'h00;
            m_ldr      = 8'h00;
            m_ack      = 1'b0;
        end else begin
            if (m_clearing) begin
                m_mem[m_clr_idx] = 8'hA5;
                m_clr_idx++;
                if (m_clr_idx == 16) m_clearing = 1'b0;
                if (cpu_cs) m_cpu = 8'hA5;
            end else if (cpu_cs) begin
                m_cpu = m_read(cpu_address);
                if (cpu_w_en && cpu_address < 5'd16 &&
                    !(wp_en && cpu_address >= 5'd4 && cpu_address <= 5'd7))
                    m_mem[cpu_address[3:0]] = cpu_din;
            end else if (ldr_req && !m_ack) begin
                nxt_ack = 1'b1;
                m_ldr = m_read(ldr_address);
                if (ldr_we && ldr_address < 5'd16) m_mem[ldr_address[3:0]] = ldr_din;
            end
            m_ack = nxt_ack;
        end
    endtask

    // One clock with the current inputs; compare all outputs to the model
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check("busy", busy, m_clearing);
        check("cpu_dout", cpu_dout, m_cpu);
        check("ldr_ack", ldr_ack, m_ack);
        if (m_ack) check("ldr_dout", ldr_dout, m_ldr);
    endtask

    task automatic cpu_op(input logic [4:0] a, input logic we, input logic [7:0] d);
        cpu_cs = 1'b1; cpu_address = a; cpu_w_en = we; cpu_din = d;
        cyc();
        cpu_cs = 1'b0; cpu_w_en = 1'b0;
    endtask

    // Pulse reset, then count how many cycles busy stays high (bounded)
    task automatic reset_and_count(output int busy_cnt);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 40 && busy; i++) begin
            cyc();
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        int cnt;
        int ack_cnt;

        // Reset values
        reset = 1'b1;
        cyc();
        check("rst_cpu_dout", cpu_dout, 8'h00);
        check("rst_ldr_dout", ldr_dout, 8'h00);
        check("rst_ldr_ack", ldr_ack, 1'b0);
        check("rst_busy", busy, 1'b1);

        // Clear sequence
        reset_and_count(cnt);
        check("clear_len", cnt, 16);
        $display("clear: busy cycles=%0d", cnt);
        for (int i = 0; i < 16; i++) begin
            cpu_op(5'(i), 1'b0, 8'h00);
            check("clr_rd", cpu_dout, 8'hA5);
        end

        // Read-before-write and out-of-range
        cpu_op(5'd2, 1'b1, 8'h3C);
        check("rbw_old", cpu_dout, 8'hA5);
        cpu_op(5'd2, 1'b0, 8'h00);
        check("rbw_new", cpu_dout, 8'h3C);
        cpu_op(5'd20, 1'b1, 8'h77);
        cpu_op(5'd20, 1'b0, 8'h00);
        check("oor_rd", cpu_dout, 8'hFF);
        $display("rbw: addr2=%h addr20=%h", 8'h3C, cpu_dout);

        // Write protect
        wp_en = 1'b1;
        cpu_op(5'd5, 1'b1, 8'h11);
        cpu_op(5'd5, 1'b0, 8'h00);
        check("wp_on", cpu_dout, 8'hA5);
        wp_en = 1'b0;
        cpu_op(5'd5, 1'b1, 8'h11);
        cpu_op(5'd5, 1'b0, 8'h00);
        check("wp_off", cpu_dout, 8'h11);
        wp_en = 1'b1;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_address = 5'd6; ldr_din = 8'h22;
        cyc();
        ldr_req = 1'b0;
        check("ldr_wr_ack", ldr_ack, 1'b1);
        cyc();
        cpu_op(5'd6, 1'b0, 8'h00);
        check("wp_ldr", cpu_dout, 8'h22);
        wp_en = 1'b0;
        $display("wp: protected=A5 unprotected=11 loader=%h", cpu_dout);

        // Arbitration: CPU holds the array, loader waits
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_address = 5'd2;
        cpu_cs = 1'b1; cpu_address = 5'd0; cpu_w_en = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            ack_cnt += int'(ldr_ack);
        end
        check("arb_wait", ack_cnt, 0);
        cpu_cs = 1'b0;
        cyc();
        check("arb_ack", ldr_ack, 1'b1);
        check("arb_dout", ldr_dout, 8'h3C);
        ldr_req = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            ack_cnt += int'(ldr_ack);
        end
        check("arb_single", ack_cnt, 0);
        $display("arb: loader read addr2=%h after cpu release", 8'h3C);

        // Held request over idle cycles
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_address = 5'd3;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            ack_cnt += int'(ldr_ack);
        end
        ldr_req = 1'b0;
        check("held_acks", ack_cnt, 3);
        cyc();
        $display("held: acks=%0d in 6 cycles", ack_cnt);

        // Reset in the middle of clear
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cpu_op(5'(i), 1'b1, 8'h5A);
        end
        reset_and_count(cnt);
        check("midclr_len", cnt, 16);
        cpu_op(5'd0, 1'b0, 8'h00);
        check("midclr_rd0", cpu_dout, 8'hA5);
        $display("midclear: busy cycles=%0d", cnt);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            cpu_cs      = ($urandom_range(0, 1) == 1);
            cpu_address = 5'($urandom_range(0, 31));
            cpu_w_en    = ($urandom_range(0, 1) == 1);
            cpu_din     = 8'($urandom);
            wp_en       = ($urandom_range(0, 1) == 1);
            if (!ldr_req && $urandom_range(0, 2) == 0) begin
                ldr_req     = 1'b1;
                ldr_we      = ($urandom_range(0, 1) == 1);
                ldr_address = 5'($urandom_range(0, 31));
                ldr_din     = 8'($urandom);
            end
            cyc();
            if (ldr_ack) begin
                $display("ldr txn: we=%0d addr=%0d dout=%h", ldr_we, ldr_address, ldr_dout);
                ldr_req = 1'b0;
            end
        end
        reset = 1'b0;
        cpu_cs = 1'b0;
        ldr_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
